// File: rtl/rv_multicycle_sequencer.sv
// Multicycle RV32 control sequencer: walks each instruction through FETCH, DECODE,
// EXEC, MEM and WB and produces the datapath strobes. Memory handshakes are guarded
// by a wait counter that drops into an absorbing FAULT state on timeout.
module rv_multicycle_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode_i,
  input  logic       branch_taken_i,
  output logic       imem_req_o,
  input  logic       imem_ready_i,
  output logic       dmem_req_o,
  output logic       dmem_we_o,
  input  logic       dmem_ready_i,
  output logic       ir_we_o,
  output logic       rf_we_o,
  output logic       pc_we_o,
  output logic [1:0] pc_sel_o,
  output logic       retire_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StIdle   = 3'd5,
    StFault  = 3'd7
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  localparam logic [1:0] PcPlus4 = 2'd0;
  localparam logic [1:0] PcImm   = 2'd1;
  localparam logic [1:0] PcAlu   = 2'd2;

  // Last counter value at which a still-pending request is abandoned.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;

  logic is_mem, is_store, is_branch, is_wb, is_jal, is_jalr;

  assign is_store  = (opcode_i == OpStore);
  assign is_mem    = (opcode_i == OpLoad) || is_store;
  assign is_branch = (opcode_i == OpBranch);
  assign is_jal    = (opcode_i == OpJal);
  assign is_jalr   = (opcode_i == OpJalr);
  assign is_wb     = (opcode_i == OpR) || (opcode_i == OpI) || (opcode_i == OpLui) ||
                     (opcode_i == OpAuipc) || is_jal || is_jalr;

  // Next-state and wait-counter update.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (imem_ready_i) begin
          state_d = StDecode;
        end else if (wait_q == TimeoutLast) begin
          state_d = StFault;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StDecode: state_d = StExec;
      StExec: begin
        if (is_mem) begin
          state_d = StMem;
        end else if (is_branch) begin
          state_d = StFetch;
        end else if (is_wb) begin
          state_d = StWb;
        end else begin
          state_d = StFault;
        end
      end
      StMem: begin
        if (dmem_ready_i) begin
          state_d = is_store ? StFetch : StWb;
        end else if (wait_q == TimeoutLast) begin
          state_d = StFault;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      StWb:    state_d = StFetch;
      StFault: state_d = StFault;
      default: state_d = StFault;
    endcase
    // Each new handshake starts its timeout budget from zero.
    if ((state_d != state_q) && ((state_d == StFetch) || (state_d == StMem))) begin
      wait_d = 8'd0;
    end
  end

  // State and wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Strobes decoded from state; IDLE decodes to all-low so reset silences outputs at once.
  always_comb begin
    imem_req_o = 1'b0;
    ir_we_o    = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    rf_we_o    = 1'b0;
    pc_we_o    = 1'b0;
    pc_sel_o   = PcPlus4;
    fault_o    = 1'b0;
    unique case (state_q)
      StFetch: begin
        imem_req_o = 1'b1;
        ir_we_o    = imem_ready_i;
      end
      StExec: begin
        if (is_branch) begin
          pc_we_o  = 1'b1;
          pc_sel_o = branch_taken_i ? PcImm : PcPlus4;
        end
      end
      StMem: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = is_store;
        pc_we_o    = is_store && dmem_ready_i;
      end
      StWb: begin
        rf_we_o  = 1'b1;
        pc_we_o  = 1'b1;
        pc_sel_o = is_jal ? PcImm : (is_jalr ? PcAlu : PcPlus4);
      end
      StFault: fault_o = 1'b1;
      default: ;
    endcase
    retire_o = pc_we_o;
  end

  assign state_o = state_q;

endmodule

// File: doc/rv_multicycle_sequencer.md
RV_MULTICYCLE_SEQUENCER -- requirements
Module: rv_multicycle_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum number of cycles a memory request may wait for ready; legal range 2..255.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port opcode_i  input  7  opcode field of the instruction register; stable from DECODE until the next FETCH completes.
REQ-005 SHALL have port branch_taken_i  input  1  branch comparison result, sampled in EXEC.
REQ-006 SHALL have port imem_req_o  output  1  instruction fetch request.
REQ-007 SHALL have port imem_ready_i  input  1  instruction fetch completion.
REQ-008 SHALL have port dmem_req_o  output  1  data memory request.
REQ-009 SHALL have port dmem_we_o  output  1  data memory write enable; 1 for a store, 0 for a load.
REQ-010 SHALL have port dmem_ready_i  input  1  data memory completion.
REQ-011 SHALL have port ir_we_o  output  1  instruction register load strobe.
REQ-012 SHALL have port rf_we_o  output  1  register file write strobe.
REQ-013 SHALL have port pc_we_o  output  1  PC write strobe.
REQ-014 SHALL have port pc_sel_o  output  2  next-PC source: 0 = PC+4, 1 = PC+imm (branch/JAL), 2 = ALU result (JALR).
REQ-015 SHALL have port retire_o  output  1  one-cycle pulse for each completed instruction.
REQ-016 SHALL have port fault_o  output  1  sticky error flag.
REQ-017 SHALL have port state_o  output  3  current state encoding, for debug.

Function
REQ-018 SHALL implement the states IDLE=5, FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and FAULT=7, presented on state_o.
REQ-019 SHALL go from IDLE to FETCH unconditionally on the first clock after rst_n deasserts.
REQ-020 SHALL, in FETCH, hold imem_req_o=1 until the cycle imem_ready_i=1, and in that same cycle pulse ir_we_o and move to DECODE; ready in the first request cycle is accepted.
REQ-021 SHALL stay in DECODE exactly one cycle and then move to EXEC.
REQ-022 SHALL, in EXEC, take these transitions by opcode:
  - LOAD (0000011), STORE (0100011): go to MEM.
  - BRANCH (1100011): go to FETCH with pc_we_o=1 and pc_sel_o = branch_taken_i ? 1 : 0.
  - R (0110011), I (0010011), LUI (0110111), AUIPC (0010111), JAL (1101111), JALR (1100111): go to WB.
  - any other opcode: go to FAULT.
REQ-023 SHALL, in MEM, hold dmem_req_o=1, with dmem_we_o=1 for a store and 0 for a load, until dmem_ready_i=1; a load then goes to WB, and a store goes to FETCH with pc_we_o=1 and pc_sel_o=0 in the ready cycle.
REQ-024 SHALL, in WB, assert rf_we_o=1 and pc_we_o=1 for one cycle and go to FETCH, with pc_sel_o = 1 for JAL, 2 for JALR and 0 otherwise.
REQ-025 SHALL pulse retire_o in exactly the cycles where pc_we_o=1.
REQ-026 SHALL drive every output of the outer interface low except in the states and cycles listed above, and SHALL drive pc_sel_o=0 whenever pc_we_o=0.
REQ-027 SHALL keep an 8-bit wait counter that clears on entry to FETCH or MEM and increments each cycle a request is high without ready.
REQ-028 SHALL go to FAULT when the wait counter reaches TIMEOUT_CYCLES-1 and ready is still low; if ready arrives in that same cycle, ready wins and the normal transition occurs.
REQ-029 SHALL make FAULT absorbing: fault_o=1, all strobes and requests 0, exit only by reset.
REQ-030 SHALL generate all strobes as Moore outputs decoded from state and opcode_i, except the ready-qualified strobes (ir_we_o, and pc_we_o/retire_o in MEM), which also depend on ready.

Reset
REQ-031 SHALL, while rst_n=0, force state IDLE, wait counter 0 and fault_o=0, and hold every output low, asynchronously.
REQ-032 SHALL, on reset asserted mid-transaction (for example in MEM with dmem_req_o=1), drop all requests in the same cycle, without waiting for a clock edge.

Verification
REQ-033 SHALL cover: R-type with imem_ready_i=1 immediately -> states IDLE,FETCH,DECODE,EXEC,WB,FETCH; retire_o one pulse; 4 cycles from FETCH to the next FETCH.
REQ-034 SHALL cover: load with dmem_ready_i delayed 3 cycles -> dmem_req_o=1 for 4 cycles with dmem_we_o=0, then WB with rf_we_o=1; store -> dmem_we_o=1, no WB, pc_we_o in the ready cycle.
REQ-035 SHALL cover: branch with branch_taken_i=1 and then 0 -> pc_sel_o=1 and then 0, with pc_we_o in EXEC; JALR -> pc_sel_o=2 and rf_we_o=1 in WB.
REQ-036 SHALL cover: opcode 0000000 -> FAULT after EXEC, fault_o=1 held for 20 cycles; rst_n pulse -> IDLE with fault_o=0.
REQ-037 SHALL cover: TIMEOUT_CYCLES=4 with imem_ready_i held low -> FAULT after 4 request cycles; ready in the 4th cycle -> DECODE, no fault.
REQ-038 SHALL cover: rst_n asserted mid-MEM -> dmem_req_o=0 before the next clock edge; after release, state IDLE then FETCH.
